vga_window_gen: RTL

- Parametrised VGA timing generator with a configurable image window.
- Produces HS/VS/BLANK_N and a linear read address into a greyscale frame store of configurable read latency.
- Greyscale data replicates onto R/G/B inside the window; a constant background colour fills active area outside it.
- Sits between the pixel-clock PLL domain and the ADV-style VGA DAC; replaces the fixed 640x480 / 256x256 generator.

---
 rtl/vga_window_gen_if.sv | 34 +++
 rtl/vga_window_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_window_gen_if.sv
// Signal bundle between the VGA window generator, its greyscale frame store
// and the VGA DAC: read address/data plus the sync, blank and colour pins.
interface vga_window_gen_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              vga_hs;
  logic              vga_vs;
  logic              vga_blank_n;
  logic [7:0]        vga_r;
  logic [7:0]        vga_g;
  logic [7:0]        vga_b;
  logic              frame_start;
  logic              line_start;

  // Generator side: issues read addresses, consumes pixel data, drives pins.
  modport master (
    output ram_addr,
    input  ram_data,
    output vga_hs, vga_vs, vga_blank_n,
    output vga_r, vga_g, vga_b,
    output frame_start, line_start
  );

  // Frame store / DAC side.
  modport slave (
    input  ram_addr,
    output ram_data,
    input  vga_hs, vga_vs, vga_blank_n,
    input  vga_r, vga_g, vga_b,
    input  frame_start, line_start
  );
endinterface

// File: rtl/vga_window_gen.sv
// Parametrised VGA timing generator with an image window. Raster counters
// produce raw sync/active/window flags; a linear frame-store address is
// stepped once per window pixel; all flags ride a delay line of RD_LAT+1
// registers so the pins line up with the frame-store data.
module vga_window_gen #(
  parameter int         HDISP  = 640,
  parameter int         HFP    = 16,
  parameter int         HPULSE = 96,
  parameter int         HBP    = 48,
  parameter int         VDISP  = 480,
  parameter int         VFP    = 11,
  parameter int         VPULSE = 2,
  parameter int         VBP    = 31,
  parameter int         IMG_X0 = 0,
  parameter int         IMG_Y0 = 0,
  parameter int         IMG_W  = 256,
  parameter int         IMG_H  = 256,
  parameter int         ADDR_W = 16,
  parameter int         RD_LAT = 1,
  parameter bit         HS_POL = 1'b0,
  parameter bit         VS_POL = 1'b0,
  parameter logic [7:0] BG_R   = 8'd0,
  parameter logic [7:0] BG_G   = 8'd0,
  parameter logic [7:0] BG_B   = 8'd128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  vga_window_gen_if.master bus
);

  localparam int HTOT     = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT     = VDISP + VFP + VPULSE + VBP;
  localparam int HW       = $clog2(HTOT + 1);
  localparam int VW       = $clog2(VTOT + 1);
  localparam int PIPE_LEN = RD_LAT + 1;

  localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
  localparam logic [HW-1:0] H_DISP = HW'(HDISP);
  localparam logic [HW-1:0] HS_BEG = HW'(HDISP + HFP);
  localparam logic [HW-1:0] HS_LEN = HW'(HPULSE);
  localparam logic [HW-1:0] X_BEG  = HW'(IMG_X0);
  localparam logic [HW-1:0] X_LEN  = HW'(IMG_W);

  localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
  localparam logic [VW-1:0] V_DISP = VW'(VDISP);
  localparam logic [VW-1:0] VS_BEG = VW'(VDISP + VFP);
  localparam logic [VW-1:0] VS_LEN = VW'(VPULSE);
  localparam logic [VW-1:0] Y_BEG  = VW'(IMG_Y0);
  localparam logic [VW-1:0] Y_LEN  = VW'(IMG_H);

  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_W * IMG_H - 1);

  // Elaboration-time sanity checks on the configuration.
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("vga_window_gen: RD_LAT must be in 1..4");
  end
  if (IMG_W < 1 || IMG_H < 1 || IMG_X0 < 0 || IMG_Y0 < 0 ||
      IMG_X0 + IMG_W > HDISP || IMG_Y0 + IMG_H > VDISP) begin : g_bad_window
    $error("vga_window_gen: image window exceeds the active display");
  end
  if ((longint'(1) << ADDR_W) < longint'(IMG_W) * longint'(IMG_H)) begin : g_bad_addr_w
    $error("vga_window_gen: ADDR_W too small for IMG_W*IMG_H");
  end

  // Per-pixel flags carried down the alignment delay line. hs/vs hold pin
  // levels (polarity already applied) so the last stage drives pins directly.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic win;
    logic fs;
    logic ls;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, act: 1'b0,
                                    win: 1'b0, fs: 1'b0, ls: 1'b0};

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  stage_t            s0_d;
  stage_t            pipe_q [PIPE_LEN];
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;
  logic [7:0]        b_q, b_d;

  // Region decode; offset-and-compare keeps ranges starting at 0 well-formed.
  logic h_act, v_act, in_x, in_y, in_hs, in_vs, frame_end;
  assign h_act     = h_cnt_q < H_DISP;
  assign v_act     = v_cnt_q < V_DISP;
  assign in_x      = (h_cnt_q - X_BEG) < X_LEN;
  assign in_y      = (v_cnt_q - Y_BEG) < Y_LEN;
  assign in_hs     = (h_cnt_q - HS_BEG) < HS_LEN;
  assign in_vs     = (v_cnt_q - VS_BEG) < VS_LEN;
  assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  // Raster counters: hold at origin while disabled, otherwise scan the frame.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Stage 0 flags straight from the counters; idle levels while disabled so
  // the delay line drains to a quiet state.
  always_comb begin
    s0_d = STAGE_IDLE;
    if (en) begin
      s0_d.hs  = in_hs ? HS_POL : ~HS_POL;
      s0_d.vs  = in_vs ? VS_POL : ~VS_POL;
      s0_d.act = h_act && v_act;
      s0_d.win = h_act && v_act && in_x && in_y;
      s0_d.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
      s0_d.ls  = (h_cnt_q == '0) && v_act;
    end
  end

  // Address of the next window pixel: steps once per window pixel, never past
  // the last image pixel, and returns to 0 only at frame end or when disabled.
  always_comb begin
    addr_d = addr_q;
    if (!en || frame_end) begin
      addr_d = '0;
    end else if (s0_d.win && (addr_q != A_LAST)) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Colour for the pixel whose frame-store data is arriving now.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (pipe_q[PIPE_LEN-2].win) begin
      r_d = bus.ram_data;
      g_d = bus.ram_data;
      b_d = bus.ram_data;
    end else if (pipe_q[PIPE_LEN-2].act) begin
      r_d = BG_R;
      g_d = BG_G;
      b_d = BG_B;
    end
  end

  // State registers: counters, address, alignment delay line and colour.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      // NOTE: the delay line is a handful of flops, not a RAM, so it is reset like any other register.
      for (int i = 0; i < PIPE_LEN; i++) begin
        pipe_q[i] <= STAGE_IDLE;
      end
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      addr_q    <= addr_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      pipe_q[0] <= s0_d;
      for (int i = 1; i < PIPE_LEN; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.ram_addr    = addr_q;
  assign bus.vga_hs      = pipe_q[PIPE_LEN-1].hs;
  assign bus.vga_vs      = pipe_q[PIPE_LEN-1].vs;
  assign bus.vga_blank_n = pipe_q[PIPE_LEN-1].act;
  assign bus.frame_start = pipe_q[PIPE_LEN-1].fs;
  assign bus.line_start  = pipe_q[PIPE_LEN-1].ls;
  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;

endmodule
